// File: rtl/mp_add_pkg.sv
// Shared types and default sizing for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_W     = 64;
  localparam int unsigned DEF_WORDS = 4;

endpackage

// File: rtl/add_core_w.sv
// Combinational W-bit adder with carry in/out; the single datapath reused for every word.
module add_core_w #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s    = sum[W-1:0];
    cout = sum[W];
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Streams WORDS operand pairs LS-word first through one add_core_w, chaining carry/borrow,
// and presents each result word through a one-entry output register.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  output logic         busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_word,
  input  logic [W-1:0] b_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_word,
  output logic         out_last,
  output logic         c_out
);

  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          sub_q;

  logic [W-1:0]  b_eff;
  logic [W-1:0]  sum;
  logic          cout;
  logic          accept;
  logic          is_last;

  // Subtract is A + ~B + 1: the +1 comes from carry being seeded with sub at start.
  always_comb begin
    b_eff    = b_word ^ {W{sub_q}};
    in_ready = (state == RUN) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    is_last  = (cnt == LAST_IDX);
  end

  add_core_w #(.W(W)) u_core (
    .a    (a_word),
    .b    (b_eff),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      sub_q     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_last  <= 1'b0;
      c_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sub_q <= sub;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            out_word  <= sum;
            out_valid <= 1'b1;
            out_last  <= is_last;
            c_out     <= is_last ? cout : 1'b0;
            carry     <= cout;
            if (is_last) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer: 256-bit reference arithmetic, queued expected words.
`timescale 1ns/1ps
module tb_mp_add_sequencer;

  localparam int unsigned W     = 64;
  localparam int unsigned WORDS = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_word;
  logic [W-1:0] b_word;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         out_last;
  logic         c_out;

  typedef struct {
    logic [W-1:0] word;
    logic         last;
    logic         c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mp_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .c_out     (c_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack4(input logic [63:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Reference result from full-width arithmetic, split into expected words.
  task automatic push_op(input logic [255:0] a, input logic [255:0] b, input logic s);
    logic [256:0] r;
    logic         c;
    if (s) begin
      r = {1'b0, a - b};
      c = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
      c = r[256];
    end
    for (int i = 0; i < WORDS; i++) begin
      exp_t e;
      e.word = r[i*64 +: 64];
      e.last = (i == WORDS - 1);
      e.c    = (i == WORDS - 1) ? c : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_op(input logic [255:0] a, input logic [255:0] b, input logic s,
                         input int nwords);
    bit ok;
    push_op(a, b, s);
    @(posedge clk); #1;
    start = 1'b1;
    sub   = s;
    @(negedge clk);
    check("busy_pre", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_rise", busy, 1);
    for (int w = 0; w < nwords; w++) begin
      in_valid = 1'b1;
      a_word   = a[w*64 +: 64];
      b_word   = b[w*64 +: 64];
      ok = 0;
      for (int t = 0; t < 50; t++) begin
        if (t != 0 || w != 0) @(negedge clk);
        if (in_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) check("in_timeout", 1, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        @(negedge clk);
        check("busy_end", busy, 0);
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 1, 0);
      end else begin
        e_mon = exp_q.pop_front();
        check("out_word", out_word, e_mon.word);
        check("out_last", out_last, e_mon.last);
        if (e_mon.last) check("c_out", c_out, e_mon.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [63:0]  held;
    logic [255:0] ra, rb;
    logic [63:0]  ones;
    ones      = '1;
    rst       = 1'b1;
    start     = 1'b0;
    sub       = 1'b0;
    in_valid  = 1'b0;
    a_word    = '0;
    b_word    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_last", out_last, 0);
    check("rst_c_out", c_out, 0);
    rst = 1'b0;

    // plain add, no carries
    send_op(pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 1'b0, 4);
    wait_done();

    // in_valid ignored while idle
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // carry ripples through every word
    send_op(pack4(ones, ones, ones, ones), pack4(1, 0, 0, 0), 1'b0, 4);
    wait_done();

    // subtract with borrow, then equal operands
    send_op(pack4(0, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 4);
    wait_done();
    send_op(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 1'b1, 4);
    wait_done();

    // backpressure after the first result word, with a stray start/sub during the stall
    fork
      send_op(pack4(100, 200, 300, 400), pack4(7, 8, 9, 10), 1'b0, 4);
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (out_valid) break;
        end
        out_ready = 1'b0;
        held  = out_word;
        sub   = 1'b1;
        start = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_hold", out_word, held);
          check("stall_valid", out_valid, 1);
          @(posedge clk); #1;
          start = 1'b0;
        end
        sub       = 1'b0;
        out_ready = 1'b1;
      end
    join
    wait_done();

    // reset after two operand pairs accepted
    send_op(pack4(ones, ones, 9, 9), pack4(1, 1, 9, 9), 1'b0, 2);
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_out_word", out_word, 0);
    check("mid_out_last", out_last, 0);
    check("mid_c_out", c_out, 0);
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;

    send_op(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b0, 4);
    wait_done();

    // random operands, both directions
    for (int k = 0; k < 4; k++) begin
      ra = pack4({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      rb = pack4({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      send_op(ra, rb, k[0], 4);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
